seq_frame_config_mem: RTL and testbench

SEQ_FRAME_CONFIG_MEM -- requirements
Module: seq_frame_config_mem

---
 rtl/seq_frame_config_mem.sv | 175 +++++++++++++++++
 tb/tb_seq_frame_config_mem.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_config_mem.sv
// Frame configuration memory with double buffering.
// Frames are written into a shadow array. A Commit pulse copies the whole
// shadow array into the active array that drives ConfigBits. A readback
// request returns one active frame, realigned to its FrameData bit position.
module seq_frame_config_mem #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned FrameBitsUsed   = 20,
    parameter int unsigned FrameBitOffset  = 12,
    localparam int unsigned NoConfigBits   = MaxFramesPerCol * FrameBitsUsed,
    localparam int unsigned AW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [AW-1:0]              FrameAddr,
    input  logic                       FrameWrValid,
    output logic                       FrameWrReady,
    input  logic                       Commit,
    input  logic                       RbReq,
    input  logic [AW-1:0]              RbAddr,
    output logic                       RbValid,
    output logic [FrameBitsPerRow-1:0] RbData,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N,
    output logic                       AddrErr
);

    // One extra bit so that a power-of-two frame count still fits.
    localparam logic [AW:0] LP_MAX = (AW+1)'(MaxFramesPerCol);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMMIT,
        ST_RB
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [FrameBitsUsed-1:0]   r_shadow [MaxFramesPerCol];
    logic [FrameBitsUsed-1:0]   r_active [MaxFramesPerCol];

    logic [AW-1:0]              r_rb_addr;
    logic                       r_rb_in_range;
    logic                       r_rb_valid;
    logic [FrameBitsPerRow-1:0] r_rb_data;
    logic                       r_addr_err;

    logic                       w_wr_fire;
    logic                       w_wr_in_range;
    logic                       w_rb_in_range;
    logic                       w_commit_start;
    logic                       w_rb_start;
    logic [FrameBitsPerRow-1:0] w_rb_word;
    logic [NoConfigBits-1:0]    w_cfg;
    logic                       w_unused_data;

    assign w_wr_fire      = FrameWrValid & FrameWrReady;
    assign w_wr_in_range  = ({1'b0, FrameAddr} < LP_MAX);
    assign w_rb_in_range  = ({1'b0, RbAddr} < LP_MAX);
    // Commit has priority over a readback request in the same idle cycle.
    assign w_commit_start = (r_state == ST_IDLE) & Commit;
    assign w_rb_start     = (r_state == ST_IDLE) & ~Commit & RbReq;
    // FrameData bits outside the used field carry no configuration.
    assign w_unused_data  = ^FrameData;

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; writes are only accepted while idle.
    always_comb begin
        w_state_next = r_state;
        FrameWrReady = 1'b0;
        case (r_state)
            ST_IDLE: begin
                FrameWrReady = 1'b1;
                if (Commit) begin
                    w_state_next = ST_COMMIT;
                end else if (RbReq) begin
                    w_state_next = ST_RB;
                end
            end
            ST_COMMIT: w_state_next = ST_IDLE;
            ST_RB:     w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Shadow array: accepted in-range writes load the used field of FrameData.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
                r_shadow[f] <= '0;
            end
        end else if (w_wr_fire && w_wr_in_range) begin
            r_shadow[FrameAddr] <= FrameData[FrameBitOffset +: FrameBitsUsed];
        end
    end

    // Active array: whole shadow copied at the closing edge of the commit cycle.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
                r_active[f] <= '0;
            end
        end else if (r_state == ST_COMMIT) begin
            for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
                r_active[f] <= r_shadow[f];
            end
        end
    end

    // Readback address capture when the request is taken.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_rb_addr     <= '0;
            r_rb_in_range <= 1'b0;
        end else if (w_rb_start) begin
            r_rb_addr     <= RbAddr;
            r_rb_in_range <= w_rb_in_range;
        end
    end

    // Realign the selected active frame into a FrameData-shaped word.
    always_comb begin
        w_rb_word = '0;
        if (r_rb_in_range) begin
            w_rb_word[FrameBitOffset +: FrameBitsUsed] = r_active[r_rb_addr];
        end
    end

    // Readback response: one-cycle valid pulse, data held until the next one.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_rb_valid <= 1'b0;
            r_rb_data  <= '0;
        end else if (r_state == ST_RB) begin
            r_rb_valid <= 1'b1;
            r_rb_data  <= w_rb_word;
        end else begin
            r_rb_valid <= 1'b0;
        end
    end

    // Sticky address error for out-of-range writes or readbacks.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if ((w_wr_fire && !w_wr_in_range) || (w_rb_start && !w_rb_in_range)) begin
            r_addr_err <= 1'b1;
        end
    end

    // Flatten the active array into the configuration bus.
    always_comb begin
        w_cfg = '0;
        for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
            w_cfg[f*FrameBitsUsed +: FrameBitsUsed] = r_active[f];
        end
    end

    assign ConfigBits   = w_cfg;
    assign ConfigBits_N = ~w_cfg;
    assign RbValid      = r_rb_valid;
    assign RbData       = r_rb_data;
    assign AddrErr      = r_addr_err;

endmodule

// File: tb/tb_seq_frame_config_mem.sv
// Self-checking bench for seq_frame_config_mem with a transaction-level model.
module tb_seq_frame_config_mem;

    localparam int NF   = 20;
    localparam int ROW  = 32;
    localparam int USED = 20;
    localparam int OFS  = 12;
    localparam int NCB  = NF * USED;
    localparam int AW   = 5;

    logic            CLK;
    logic            reset;
    logic [ROW-1:0]  FrameData;
    logic [AW-1:0]   FrameAddr;
    logic            FrameWrValid;
    logic            FrameWrReady;
    logic            Commit;
    logic            RbReq;
    logic [AW-1:0]   RbAddr;
    logic            RbValid;
    logic [ROW-1:0]  RbData;
    logic [NCB-1:0]  ConfigBits;
    logic [NCB-1:0]  ConfigBits_N;
    logic            AddrErr;

    int checks   = 0;
    int failures = 0;

    // Reference model: two frame arrays and the sticky error flag.
    logic [USED-1:0] m_shadow [NF];
    logic [USED-1:0] m_active [NF];
    logic            m_err;

    seq_frame_config_mem #(
        .MaxFramesPerCol(NF),
        .FrameBitsPerRow(ROW),
        .FrameBitsUsed(USED),
        .FrameBitOffset(OFS)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .FrameData(FrameData),
        .FrameAddr(FrameAddr),
        .FrameWrValid(FrameWrValid),
        .FrameWrReady(FrameWrReady),
        .Commit(Commit),
        .RbReq(RbReq),
        .RbAddr(RbAddr),
        .RbValid(RbValid),
        .RbData(RbData),
        .ConfigBits(ConfigBits),
        .ConfigBits_N(ConfigBits_N),
        .AddrErr(AddrErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [NCB-1:0] model_cfg();
        logic [NCB-1:0] v;
        v = '0;
        for (int f = 0; f < NF; f++) v[f*USED +: USED] = m_active[f];
        return v;
    endfunction

    function automatic logic [ROW-1:0] model_rb(input int addr);
        logic [ROW-1:0] w;
        w = '0;
        if (addr < NF) w[OFS +: USED] = m_active[addr];
        return w;
    endfunction

    task automatic model_clear();
        for (int f = 0; f < NF; f++) begin
            m_shadow[f] = '0;
            m_active[f] = '0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_write(input int addr, input logic [ROW-1:0] data);
        if (addr < NF) m_shadow[addr] = data[OFS +: USED];
        else           m_err = 1'b1;
    endtask

    task automatic model_commit();
        for (int f = 0; f < NF; f++) m_active[f] = m_shadow[f];
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        FrameData    = '0;
        FrameAddr    = '0;
        FrameWrValid = 1'b0;
        Commit       = 1'b0;
        RbReq        = 1'b0;
        RbAddr       = '0;
    endtask

    // Single write while idle.
    task automatic do_write(input int addr, input logic [ROW-1:0] data);
        FrameWrValid = 1'b1;
        FrameAddr    = AW'(addr);
        FrameData    = data;
        cyc();
        FrameWrValid = 1'b0;
        model_write(addr, data);
    endtask

    // Commit pulse plus the commit cycle itself.
    task automatic do_commit();
        Commit = 1'b1;
        cyc();
        Commit = 1'b0;
        cyc();
        model_commit();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        model_clear();
        cyc();
        cyc();
        checks++;
        if (ConfigBits !== '0) begin
            failures++;
            $display("FAIL reset_cfg got=%0h exp=0", ConfigBits);
        end
        checks++;
        if (ConfigBits_N !== '1) begin
            failures++;
            $display("FAIL reset_cfg_n got=%0h exp=all ones", ConfigBits_N);
        end
        checks++;
        if (RbValid !== 1'b0 || RbData !== '0 || AddrErr !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs rbvalid=%b rbdata=%0h addrerr=%b exp 0/0/0", RbValid, RbData, AddrErr);
        end
        reset = 1'b0;
        cyc();
        checks++;
        if (FrameWrReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", FrameWrReady);
        end
    endtask

    task automatic test_write_then_commit();
        do_write(3, 32'hFFFFF000);
        cyc();
        checks++;
        if (ConfigBits !== '0) begin
            failures++;
            $display("FAIL shadow_only got=%0h exp=0", ConfigBits);
        end
        Commit = 1'b1;
        cyc();
        Commit = 1'b0;
        checks++;
        if (FrameWrReady !== 1'b0 || ConfigBits !== '0) begin
            failures++;
            $display("FAIL commit_cycle ready=%b cfg=%0h exp ready=0 cfg=0", FrameWrReady, ConfigBits);
        end
        cyc();
        model_commit();
        checks++;
        if (ConfigBits[79:60] !== 20'hFFFFF || ConfigBits !== model_cfg()) begin
            failures++;
            $display("FAIL commit_f3 got=%0h exp=%0h", ConfigBits[79:60], 20'hFFFFF);
        end
        checks++;
        if (ConfigBits_N !== ~model_cfg()) begin
            failures++;
            $display("FAIL commit_inv got=%0h exp=%0h", ConfigBits_N, ~model_cfg());
        end
    endtask

    task automatic test_write_with_commit();
        FrameWrValid = 1'b1;
        FrameAddr    = 0;
        FrameData    = 32'h0ABCD000;
        Commit       = 1'b1;
        cyc();
        FrameWrValid = 1'b0;
        Commit       = 1'b0;
        model_write(0, 32'h0ABCD000);
        cyc();
        model_commit();
        checks++;
        if (ConfigBits[19:0] !== 20'h0ABCD || ConfigBits !== model_cfg()) begin
            failures++;
            $display("FAIL same_cycle_commit got=%0h exp=%0h", ConfigBits[19:0], 20'h0ABCD);
        end
    endtask

    task automatic test_readback();
        RbReq  = 1'b1;
        RbAddr = 3;
        cyc();
        RbReq  = 1'b0;
        checks++;
        if (RbValid !== 1'b0 || FrameWrReady !== 1'b0) begin
            failures++;
            $display("FAIL rb_busy rbvalid=%b ready=%b exp 0/0", RbValid, FrameWrReady);
        end
        cyc();
        checks++;
        if (RbValid !== 1'b1 || RbData !== 32'hFFFFF000) begin
            failures++;
            $display("FAIL rb_data valid=%b data=%0h exp 1/fffff000", RbValid, RbData);
        end
        cyc();
        checks++;
        if (RbValid !== 1'b0 || FrameWrReady !== 1'b1) begin
            failures++;
            $display("FAIL rb_pulse valid=%b ready=%b exp 0/1", RbValid, FrameWrReady);
        end
    endtask

    task automatic test_addr_err();
        do_write(25, 32'h12345000);
        checks++;
        if (AddrErr !== 1'b1) begin
            failures++;
            $display("FAIL addr_err_set got=%b exp=1", AddrErr);
        end
        do_commit();
        checks++;
        if (ConfigBits !== model_cfg() || AddrErr !== 1'b1) begin
            failures++;
            $display("FAIL addr_err_sticky cfg=%0h err=%b exp cfg=%0h err=1", ConfigBits, AddrErr, model_cfg());
        end
    endtask

    task automatic test_collisions();
        do_write(7, 32'h55555000);
        // Commit and readback together: only the commit happens.
        Commit = 1'b1;
        RbReq  = 1'b1;
        RbAddr = 7;
        cyc();
        Commit = 1'b0;
        // Requests during the commit cycle are ignored, as is a write.
        FrameWrValid = 1'b1;
        FrameAddr    = 9;
        FrameData    = 32'hAAAAA000;
        cyc();
        model_commit();
        RbReq        = 1'b0;
        FrameWrValid = 1'b0;
        checks++;
        if (RbValid !== 1'b0 || ConfigBits !== model_cfg()) begin
            failures++;
            $display("FAIL collide_commit valid=%b cfg=%0h exp 0/%0h", RbValid, ConfigBits, model_cfg());
        end
        cyc();
        checks++;
        if (RbValid !== 1'b0) begin
            failures++;
            $display("FAIL collide_no_rb got=%b exp=0", RbValid);
        end
        do_commit();
        checks++;
        if (ConfigBits !== model_cfg()) begin
            failures++;
            $display("FAIL busy_write_dropped got=%0h exp=%0h", ConfigBits, model_cfg());
        end
    endtask

    task automatic test_reset_during_rb();
        RbReq  = 1'b1;
        RbAddr = 7;
        cyc();
        RbReq  = 1'b0;
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if (ConfigBits !== '0 || ConfigBits_N !== '1 || AddrErr !== 1'b0 || RbData !== '0) begin
            failures++;
            $display("FAIL abort_reset cfg=%0h err=%b rbdata=%0h exp 0/0/0", ConfigBits, AddrErr, RbData);
        end
        cyc();
        checks++;
        if (RbValid !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_rb got=%b exp=0", RbValid);
        end
        reset = 1'b0;
        cyc();
        checks++;
        if (RbValid !== 1'b0 || FrameWrReady !== 1'b1) begin
            failures++;
            $display("FAIL abort_after valid=%b ready=%b exp 0/1", RbValid, FrameWrReady);
        end
    endtask

    task automatic test_random();
        int op;
        int addr;
        logic [ROW-1:0] data;
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                addr = int'($urandom_range(0, 22));
                data = $urandom;
                do_write(addr, data);
            end else if (op == 1) begin
                do_commit();
            end else begin
                addr = int'($urandom_range(0, 21));
                RbReq  = 1'b1;
                RbAddr = AW'(addr);
                cyc();
                RbReq  = 1'b0;
                if (addr >= NF) m_err = 1'b1;
                cyc();
                checks++;
                if (RbValid !== 1'b1 || RbData !== model_rb(addr)) begin
                    failures++;
                    $display("FAIL rand_rb addr=%0d valid=%b data=%0h exp 1/%0h", addr, RbValid, RbData, model_rb(addr));
                end
            end
            checks++;
            if (ConfigBits !== model_cfg() || ConfigBits_N !== ~model_cfg() || AddrErr !== m_err) begin
                failures++;
                $display("FAIL rand_state op=%0d err=%b exp_err=%b cfg_match=%b", op, AddrErr, m_err, ConfigBits === model_cfg());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_clear();
        test_reset();
        test_write_then_commit();
        test_write_with_commit();
        test_readback();
        test_addr_err();
        test_collisions();
        test_reset_during_rb();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
